// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low column strobes, debounces whole scans,
// rejects multi-key presses and shifts accepted hex codes into an 8-digit register.
module keypad_scanner #(
    parameter int SCAN_INTERVAL  = 10000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [31:0] digits
);

    localparam int CNT_W = $clog2(SCAN_INTERVAL);
    localparam int MC_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_INTERVAL - 1);
    localparam logic [MC_W-1:0]  MC_FULL  = MC_W'(DEBOUNCE_SCANS);
    // Nibble {r,c} holds the code printed on that key.
    localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_e;
    typedef enum logic {ST_IDLE, ST_PRESSED} state_e;

    logic [3:0]       row_meta_q, row_sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       c_q, c_d;
    res_e             acc_kind_q, acc_kind_d;
    logic [3:0]       acc_code_q, acc_code_d;
    res_e             cand_kind_q, cand_kind_d;
    logic [3:0]       cand_code_q, cand_code_d;
    logic [MC_W-1:0]  match_q, match_d;
    logic             eval_q, eval_d;
    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [3:0]       code_q, code_d;
    logic [31:0]      digits_q, digits_d;

    logic [3:0]  low;
    logic [2:0]  hits;
    logic [1:0]  row_idx;
    logic [3:0]  col_code;
    logic        sample;
    res_e        merged_kind;
    logic [3:0]  merged_code;
    logic        same_as_cand;
    logic [31:0] digits_base;

    always_comb begin
        low     = ~row_sync_q;
        hits    = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
        row_idx = 2'd0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (low[3-r]) row_idx = 2'(3 - r);
        end
        col_code = KEYMAP[4*int'({row_idx, c_q}) +: 4];
        sample   = (cnt_q == CNT_LAST);

        // Fold this column's hits into the scan accumulated so far.
        merged_kind = RES_NONE;
        merged_code = '0;
        if (acc_kind_q == RES_MULTI || hits > 3'd1 ||
            (acc_kind_q == RES_SINGLE && hits == 3'd1)) begin
            merged_kind = RES_MULTI;
        end else if (acc_kind_q == RES_SINGLE) begin
            merged_kind = RES_SINGLE;
            merged_code = acc_code_q;
        end else if (hits == 3'd1) begin
            merged_kind = RES_SINGLE;
            merged_code = col_code;
        end
        same_as_cand = (merged_kind == cand_kind_q) &&
                       (merged_kind != RES_SINGLE || merged_code == cand_code_q);

        cnt_d       = sample ? '0 : cnt_q + CNT_W'(1);
        c_d         = sample ? c_q + 2'd1 : c_q;
        acc_kind_d  = acc_kind_q;
        acc_code_d  = acc_code_q;
        cand_kind_d = cand_kind_q;
        cand_code_d = cand_code_q;
        match_d     = match_q;
        eval_d      = 1'b0;

        if (sample) begin
            if (c_q == 2'd3) begin
                acc_kind_d = RES_NONE;
                acc_code_d = '0;
                eval_d     = 1'b1;
                if (merged_kind == RES_MULTI) begin
                    cand_kind_d = RES_MULTI;
                    cand_code_d = '0;
                    match_d     = '0;
                end else if (!same_as_cand) begin
                    cand_kind_d = merged_kind;
                    cand_code_d = merged_code;
                    match_d     = MC_W'(1);
                end else if (match_q != MC_FULL) begin
                    match_d = match_q + MC_W'(1);
                end
            end else begin
                acc_kind_d = merged_kind;
                acc_code_d = merged_code;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = 1'b0;
        code_d      = code_q;
        digits_base = clear ? '0 : digits_q;
        digits_d    = digits_base;
        if (eval_q && match_q == MC_FULL) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cand_kind_q == RES_SINGLE) begin
                        state_d  = ST_PRESSED;
                        valid_d  = 1'b1;
                        code_d   = cand_code_q;
                        digits_d = {digits_base[27:0], cand_code_q};
                    end
                end
                ST_PRESSED: begin
                    if (cand_kind_q == RES_NONE) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            row_meta_q  <= '1;
            row_sync_q  <= '1;
            cnt_q       <= '0;
            c_q         <= '0;
            acc_kind_q  <= RES_NONE;
            acc_code_q  <= '0;
            cand_kind_q <= RES_NONE;
            cand_code_q <= '0;
            match_q     <= '0;
            eval_q      <= 1'b0;
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            code_q      <= '0;
            digits_q    <= '0;
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            acc_kind_q  <= acc_kind_d;
            acc_code_q  <= acc_code_d;
            cand_kind_q <= cand_kind_d;
            cand_code_q <= cand_code_d;
            match_q     <= match_d;
            eval_q      <= eval_d;
            state_q     <= state_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            digits_q    <= digits_d;
        end
    end

    assign col       = ~(4'b0001 << c_q);
    assign key_valid = valid_q & ~Reset;
    assign key_code  = code_q;
    assign key_held  = (state_q == ST_PRESSED);
    assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad matrix drives rows from the
// column strobes; expected codes and digit strings are worked out by hand.
module tb_keypad_scanner;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  row;
    logic        clear;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [31:0] digits;

    logic [15:0] pressed;   // bit r*4+c = key at row r, column c is down

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;
    int dbl_pulse = 0;
    int valid_in_reset = 0;
    logic prev_valid = 1'b0;

    keypad_scanner #(.SCAN_INTERVAL(8), .DEBOUNCE_SCANS(2)) dut (
        .Clk(Clk), .Reset(Reset), .row(row), .clear(clear), .col(col),
        .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .digits(digits)
    );

    always #5 Clk = ~Clk;

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign row[r] = ~|(pressed[r*4 +: 4] & ~col);
    end

    always @(negedge Clk) begin
        if (key_valid === 1'b1) pulse_cnt++;
        if (key_valid === 1'b1 && prev_valid === 1'b1) dbl_pulse++;
        if (key_valid === 1'b1 && Reset === 1'b1) valid_in_reset++;
        prev_valid = key_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge Clk);
            if (key_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_release(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge Clk);
            if (key_held === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic align_scan(output bit ok);
        int n = 0;
        while (col !== 4'b0111 && n < 64) begin @(negedge Clk); n++; end
        while (col !== 4'b1110 && n < 64) begin @(negedge Clk); n++; end
        ok = (col === 4'b1110);
    endtask

    task automatic tap(input int idx, input logic [3:0] code, input string tag);
        bit seen, ok;
        pressed = 16'b1 << idx;
        wait_valid(99, seen);
        check({tag, "_event"}, 32'(seen), 32'd1);
        check({tag, "_code"}, 32'(key_code), 32'(code));
        check({tag, "_held"}, 32'(key_held), 32'd1);
        pressed = '0;
        wait_release(96, ok);
        check({tag, "_release"}, 32'(ok), 32'd1);
    endtask

    localparam int K1 = 0,  K2 = 1,  K3 = 2,  KA = 3;
    localparam int K4 = 4,  K5 = 5,  K6 = 6,  KB = 7;
    localparam int K7 = 8,  K9 = 10, KC = 11, KD = 15;

    initial begin
        bit seen, ok;
        int p0;

        Reset = 1'b1; clear = 1'b0; pressed = '0;
        repeat (3) @(negedge Clk);
        check("rst_col", 32'(col), 32'h0000000E);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        check("rst_digits", digits, 32'd0);

        // Column walk: each strobe held for 8 cycles starting right after reset.
        Reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("walk_col_%0d", i), 32'(col), 32'(~(4'b0001 << (i / 8)) & 4'hF));
            @(negedge Clk);
        end
        check("idle_no_pulse", 32'(pulse_cnt), 32'd0);

        // Single press "5", held for 5 scans.
        p0 = pulse_cnt;
        pressed = 16'b1 << K5;
        wait_valid(99, seen);
        check("k5_event", 32'(seen), 32'd1);
        check("k5_code", 32'(key_code), 32'h5);
        check("k5_digits", digits, 32'h5);
        check("k5_held", 32'(key_held), 32'd1);
        repeat (80) @(negedge Clk);
        check("k5_one_pulse", 32'(pulse_cnt - p0), 32'd1);
        pressed = '0;
        wait_release(96, ok);
        check("k5_release", 32'(ok), 32'd1);

        // Nine keys; the leading "5" is pushed out of the eight-digit window.
        p0 = pulse_cnt;
        tap(K1, 4'h1, "seq1"); tap(K2, 4'h2, "seq2"); tap(K3, 4'h3, "seq3");
        tap(KA, 4'hA, "seqA"); tap(K4, 4'h4, "seq4"); tap(K5, 4'h5, "seq5");
        tap(K6, 4'h6, "seq6"); tap(KB, 4'hB, "seqB"); tap(K7, 4'h7, "seq7");
        check("seq_pulses", 32'(pulse_cnt - p0), 32'd9);
        check("seq_digits", digits, 32'h23A456B7);

        // Bounce on "C": state flips once per scan so no two consecutive scans agree.
        align_scan(ok);
        check("bnc_align", 32'(ok), 32'd1);
        p0 = pulse_cnt;
        for (int s = 0; s < 4; s++) begin
            pressed = (s % 2 == 0) ? (16'b1 << KC) : 16'b0;
            repeat (32) @(negedge Clk);
        end
        check("bnc_no_event", 32'(pulse_cnt - p0), 32'd0);
        pressed = 16'b1 << KC;
        wait_valid(99, seen);
        check("bnc_event", 32'(seen), 32'd1);
        check("bnc_code", 32'(key_code), 32'hC);
        pressed = '0;
        wait_release(96, ok);
        check("bnc_release", 32'(ok), 32'd1);
        check("bnc_digits", digits, 32'h3A456B7C);

        // Multi-key "1"+"9" is rejected; dropping "9" leaves a clean "1".
        p0 = pulse_cnt;
        pressed = (16'b1 << K1) | (16'b1 << K9);
        repeat (192) @(negedge Clk);
        check("multi_no_event", 32'(pulse_cnt - p0), 32'd0);
        check("multi_digits", digits, 32'h3A456B7C);
        check("multi_held", 32'(key_held), 32'd0);
        pressed = 16'b1 << K1;
        wait_valid(99, seen);
        check("multi_k1_event", 32'(seen), 32'd1);
        check("multi_k1_code", 32'(key_code), 32'h1);
        check("multi_k1_digits", digits, 32'hA456B7C1);
        pressed = '0;
        wait_release(96, ok);
        check("multi_release", 32'(ok), 32'd1);

        // Reset while "D" is held, then the same held key is accepted again.
        pressed = 16'b1 << KD;
        wait_valid(99, seen);
        check("rd_event", 32'(seen), 32'd1);
        check("rd_digits", digits, 32'h456B7C1D);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check("rd_rst_col", 32'(col), 32'h0000000E);
        check("rd_rst_code", 32'(key_code), 32'd0);
        check("rd_rst_held", 32'(key_held), 32'd0);
        check("rd_rst_digits", digits, 32'd0);
        Reset = 1'b0;
        wait_valid(99, seen);
        check("rd_again_event", 32'(seen), 32'd1);
        check("rd_again_code", 32'(key_code), 32'hD);
        check("rd_again_digits", digits, 32'hD);
        pressed = '0;
        wait_release(96, ok);
        check("rd_release", 32'(ok), 32'd1);
        tap(K5, 4'h5, "pre_clr5");
        check("pre_clr_digits", digits, 32'hD5);

        // Press "D" at a scan start: accept edge is the one after negedge 64.
        align_scan(ok);
        check("clr_align", 32'(ok), 32'd1);
        pressed = 16'b1 << KD;
        repeat (64) @(negedge Clk);
        check("clr_pre_valid", 32'(key_valid), 32'd0);
        clear = 1'b1;
        @(negedge Clk);
        clear = 1'b0;
        check("clr_valid", 32'(key_valid), 32'd1);
        check("clr_code", 32'(key_code), 32'hD);
        check("clr_digits", digits, 32'hD);
        pressed = '0;
        wait_release(96, ok);
        check("clr_release", 32'(ok), 32'd1);

        check("no_double_pulse", 32'(dbl_pulse), 32'd0);
        check("no_valid_in_reset", 32'(valid_in_reset), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
